hack_exec_ctrl: RTL and testbench

Multi-cycle execute controller that sits directly upstream of the 16-bit Hack ALU. It accepts Hack instructions over a valid/ready handshake and holds the A, D and PC registers. It decodes each instruction into the ALU's x/y operands and 6-bit control word. It then captures the ALU result, writes back A/D/M, and evaluates the jump condition.

---
 rtl/hack_exec_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_hack_exec_ctrl.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hack_exec_ctrl.sv
// -----------------------------------------------------------------------------
// hack_exec_ctrl
//
// Multi-cycle execute controller for the 16-bit Hack CPU. It sits directly
// upstream of a purely combinational Hack ALU.
//
// Each instruction takes three cycles:
//   FETCH -> accept the instruction into IR (valid/ready handshake)
//   EXEC  -> drive the ALU operands/control from IR, capture the result in R
//            and capture the zero/negative flags
//   WB    -> commit A/D/M, evaluate the jump condition and update the PC
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous, active-low reset
//   instr_valid  instruction available on instr
//   instr        16-bit Hack instruction word
//   instr_ready  high in FETCH: instr is accepted when instr_valid is high
//   in_m         data-memory read data at addr_m (valid during EXEC)
//   alu_x        ALU first operand  = D
//   alu_y        ALU second operand = IR.a ? in_m : A
//   alu_c        ALU control word {zx,nx,zy,ny,f,no} = IR[11:6]
//   alu_out      ALU result
//   out_m        data-memory write data (R during the M write, else 0)
//   write_m      data-memory write strobe, one WB cycle per M-writing instr
//   addr_m       data-memory address = A[14:0]
//   pc           address of the next instruction to fetch
// -----------------------------------------------------------------------------
module hack_exec_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  input  logic [15:0] instr,
  output logic        instr_ready,
  input  logic [15:0] in_m,
  output logic [15:0] alu_x,
  output logic [15:0] alu_y,
  output logic [5:0]  alu_c,
  input  logic [15:0] alu_out,
  output logic [15:0] out_m,
  output logic        write_m,
  output logic [14:0] addr_m,
  output logic [14:0] pc
);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_WB    = 2'd2
  } state_t;

  state_t      state_reg;
  state_t      state_next;

  logic [15:0] ir_reg;
  logic [15:0] a_reg;
  logic [15:0] d_reg;
  logic [14:0] pc_reg;
  logic [15:0] r_reg;
  logic        zr_reg;
  logic        ng_reg;

  // Instruction field decode (bits 14:13 of a C-instruction are don't-care).
  logic        is_c_instr;
  logic        sel_m;
  logic        dest_a;
  logic        dest_d;
  logic        dest_m;
  logic [2:0]  jump_bits;
  logic        jump_taken;
  logic [14:0] pc_inc;

  assign is_c_instr = ir_reg[15];
  assign sel_m      = ir_reg[12];
  assign dest_a     = ir_reg[5];
  assign dest_d     = ir_reg[4];
  assign dest_m     = ir_reg[3];
  assign jump_bits  = ir_reg[2:0];

  // j1 -> negative, j2 -> zero, j3 -> strictly positive.
  assign jump_taken = (jump_bits[2] & ng_reg)
                    | (jump_bits[1] & zr_reg)
                    | (jump_bits[0] & ~ng_reg & ~zr_reg);

  // 15-bit add wraps naturally: 0x7FFF + 1 -> 0x0000.
  assign pc_inc = pc_reg + 15'd1;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_FETCH;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and control outputs
  // write_m/out_m are purely combinational from state and IR, so an
  // asynchronous reset (which forces FETCH) drops them without a clock edge.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next  = state_reg;
    instr_ready = 1'b0;
    write_m     = 1'b0;
    out_m       = 16'h0000;
    unique case (state_reg)
      ST_FETCH: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          state_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        state_next = ST_WB;
      end
      ST_WB: begin
        state_next = ST_FETCH;
        if (is_c_instr && dest_m) begin
          write_m = 1'b1;
          out_m   = r_reg;
        end
      end
      default: begin
        state_next = ST_FETCH;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // ALU operand path: combinational from IR/A/D/in_m; only meaningful in EXEC.
  // ---------------------------------------------------------------------------
  assign alu_x  = d_reg;
  assign alu_y  = sel_m ? in_m : a_reg;
  assign alu_c  = ir_reg[11:6];
  assign addr_m = a_reg[14:0];
  assign pc     = pc_reg;

  // ---------------------------------------------------------------------------
  // Datapath registers
  // All WB-cycle reads of a_reg (M address, jump target) see the value from
  // before this instruction, because the new A is only committed at the edge.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_reg <= 16'h0000;
      a_reg  <= 16'h0000;
      d_reg  <= 16'h0000;
      pc_reg <= 15'h0000;
      r_reg  <= 16'h0000;
      zr_reg <= 1'b0;
      ng_reg <= 1'b0;
    end else begin
      unique case (state_reg)
        ST_FETCH: begin
          if (instr_valid) begin
            ir_reg <= instr;
          end
        end
        ST_EXEC: begin
          // A-instructions leave R and the flags untouched.
          if (is_c_instr) begin
            r_reg  <= alu_out;
            zr_reg <= (alu_out == 16'h0000);
            ng_reg <= alu_out[15];
          end
        end
        ST_WB: begin
          if (!is_c_instr) begin
            a_reg  <= {1'b0, ir_reg[14:0]};
            pc_reg <= pc_inc;
          end else begin
            if (dest_a) begin
              a_reg <= r_reg;
            end
            if (dest_d) begin
              d_reg <= r_reg;
            end
            pc_reg <= jump_taken ? a_reg[14:0] : pc_inc;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hack_exec_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hack_exec_ctrl
//
// Drives hack_exec_ctrl with directed and random Hack instructions. The bench
// plays the role of the ALU and of data memory, and keeps an instruction-level
// model of the Hack machine (A, D, PC, memory) to predict every observable.
// -----------------------------------------------------------------------------
module tb_hack_exec_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic [15:0] instr;
  logic        instr_ready;
  logic [15:0] in_m;
  logic [15:0] alu_x;
  logic [15:0] alu_y;
  logic [5:0]  alu_c;
  logic [15:0] alu_out;
  logic [15:0] out_m;
  logic        write_m;
  logic [14:0] addr_m;
  logic [14:0] pc;

  int errors = 0;
  int checks = 0;

  // Environment memory (written only from DUT-observed writes) and the
  // model's own copy of memory.
  logic [15:0] mem     [0:32767];
  logic [15:0] ref_mem [0:32767];

  // Reference machine state.
  logic [15:0] m_a;
  logic [15:0] m_d;
  logic [14:0] m_pc;

  always #5 clk = ~clk;

  hack_exec_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .in_m        (in_m),
    .alu_x       (alu_x),
    .alu_y       (alu_y),
    .alu_c       (alu_c),
    .alu_out     (alu_out),
    .out_m       (out_m),
    .write_m     (write_m),
    .addr_m      (addr_m),
    .pc          (pc)
  );

  // Standard Hack ALU: c = {zx,nx,zy,ny,f,no}.
  function automatic logic [15:0] hack_alu(input logic [15:0] x, input logic [15:0] y,
                                           input logic [5:0] c);
    logic [15:0] xx;
    logic [15:0] yy;
    logic [15:0] o;
    xx = c[5] ? 16'h0000 : x;
    if (c[4]) xx = ~xx;
    yy = c[3] ? 16'h0000 : y;
    if (c[2]) yy = ~yy;
    o = c[1] ? (xx + yy) : (xx & yy);
    if (c[0]) o = ~o;
    return o;
  endfunction

  assign alu_out = hack_alu(alu_x, alu_y, alu_c);
  assign in_m    = mem[addr_m];

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_a  = 16'h0000;
    m_d  = 16'h0000;
    m_pc = 15'h0000;
  endtask

  // Issue one instruction and check EXEC, WB and the following FETCH cycle.
  // Entered and left at #1 after a rising edge.
  task automatic run_instr(input logic [15:0] ins);
    int          n;
    logic        is_c;
    logic [15:0] yv;
    logic [15:0] res;
    logic        taken;
    logic        exp_w;
    n = 0;
    while (instr_ready !== 1'b1 && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    if (instr_ready !== 1'b1) begin
      check("ready_timeout", {15'h0, instr_ready}, 16'h0001);
      return;
    end
    // Instruction-level prediction.
    is_c  = ins[15];
    yv    = ins[12] ? ref_mem[m_a[14:0]] : m_a;
    res   = hack_alu(m_d, yv, ins[11:6]);
    taken = (ins[2] && $signed(res) < 0) || (ins[1] && res == 16'h0000)
         || (ins[0] && $signed(res) > 0);
    exp_w = is_c && ins[3];

    instr_valid = 1'b1;
    instr       = ins;
    @(posedge clk); #1;
    // EXEC: input handshake must be ignored here.
    instr_valid = 1'($urandom_range(0, 1));
    instr       = 16'($urandom);
    check("exec_ready", {15'h0, instr_ready}, 16'h0000);
    check("exec_wm", {15'h0, write_m}, 16'h0000);
    if (is_c) begin
      check("exec_alu_c", {10'h0, alu_c}, {10'h0, ins[11:6]});
      check("exec_alu_x", alu_x, m_d);
      check("exec_alu_y", alu_y, yv);
    end
    @(posedge clk); #1;
    // WB
    instr_valid = 1'b0;
    check("wb_write_m", {15'h0, write_m}, {15'h0, exp_w});
    if (exp_w) begin
      check("wb_addr_m", {1'b0, addr_m}, {1'b0, m_a[14:0]});
      check("wb_out_m", out_m, res);
      mem[addr_m] = out_m;
    end
    // Commit to the model using the pre-instruction A.
    if (!is_c) begin
      m_a  = {1'b0, ins[14:0]};
      m_pc = m_pc + 15'd1;
    end else begin
      if (ins[3]) ref_mem[m_a[14:0]] = res;
      m_pc = taken ? m_a[14:0] : m_pc + 15'd1;
      if (ins[5]) m_a = res;
      if (ins[4]) m_d = res;
    end
    @(posedge clk); #1;
    // Back in FETCH
    check("fetch_pc", {1'b0, pc}, {1'b0, m_pc});
    check("fetch_addr_m", {1'b0, addr_m}, {1'b0, m_a[14:0]});
    check("fetch_ready", {15'h0, instr_ready}, 16'h0001);
    check("fetch_wm", {15'h0, write_m}, 16'h0000);
    check("fetch_d", alu_x, m_d);
    $display("instr %h pc=%h a=%h d=%h wm=%0d", ins, pc, m_a, m_d, exp_w);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [15:0] v;
    logic [15:0] ins;
    rst_n       = 1'b0;
    instr_valid = 1'b0;
    instr       = 16'h0000;
    for (int i = 0; i < 32768; i++) begin
      v          = 16'($urandom);
      mem[i]     = v;
      ref_mem[i] = v;
    end
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_pc", {1'b0, pc}, 16'h0000);
    check("rst_addr_m", {1'b0, addr_m}, 16'h0000);
    check("rst_write_m", {15'h0, write_m}, 16'h0000);
    check("rst_ready", {15'h0, instr_ready}, 16'h0001);
    check("rst_out_m", out_m, 16'h0000);
    release_reset();

    // Load and copy: @5; D=A
    run_instr(16'h0005);
    run_instr(16'hEC10);
    check("copy_pc", {1'b0, pc}, 16'h0002);
    check("copy_d", alu_x, 16'h0005);

    // Memory write: @0x10; M=D+1
    run_instr(16'h0010);
    run_instr(16'hE7C8);
    check("mw_mem", mem[16], 16'h0006);
    check("mw_a", {1'b0, addr_m}, 16'h0010);
    check("mw_d", alu_x, 16'h0005);

    // Jump taken: D=0; @7; D;JEQ
    run_instr(16'hEA90);
    run_instr(16'h0007);
    run_instr(16'hE302);
    check("jeq_taken_pc", {1'b0, pc}, 16'h0007);
    // Jump not taken with D=5
    run_instr(16'h0005);
    run_instr(16'hEC10);
    run_instr(16'h0007);
    run_instr(16'hE302);
    check("jeq_not_pc", {1'b0, pc}, 16'h000B);

    // PC wrap: @0x7FFF; 0;JMP; then an A-instruction
    run_instr(16'h7FFF);
    run_instr(16'hEA87);
    check("wrap_at_max", {1'b0, pc}, 16'h7FFF);
    run_instr(16'h0000);
    check("wrap_pc", {1'b0, pc}, 16'h0000);

    // Dual dest: @0x20 with M=1; AM=M-1
    mem[32]     = 16'h0001;
    ref_mem[32] = 16'h0001;
    run_instr(16'h0020);
    run_instr(16'hFCA8);
    check("dual_mem", mem[32], 16'h0000);
    check("dual_addr_after", {1'b0, addr_m}, 16'h0000);

    // Asynchronous reset pulse between edges clears outputs immediately.
    run_instr(16'h0123);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("async_pc", {1'b0, pc}, 16'h0000);
    check("async_addr_m", {1'b0, addr_m}, 16'h0000);
    check("async_ready", {15'h0, instr_ready}, 16'h0001);
    model_reset();
    release_reset();

    // Abort during EXEC of M=D+1
    run_instr(16'h0005);
    run_instr(16'hEC10);
    run_instr(16'h0010);
    instr_valid = 1'b1;
    instr       = 16'hE7C8;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    rst_n       = 1'b0;
    #1;
    check("abort_exec_wm", {15'h0, write_m}, 16'h0000);
    check("abort_exec_pc", {1'b0, pc}, 16'h0000);
    check("abort_exec_ready", {15'h0, instr_ready}, 16'h0001);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check("abort_exec_hold_wm", {15'h0, write_m}, 16'h0000);
    end
    model_reset();
    release_reset();
    check("abort_exec_d", alu_x, 16'h0000);
    check("abort_exec_mem", mem[16], 16'h0006);

    // Abort during WB: write_m drops with no clock edge, memory unchanged.
    run_instr(16'h0011);
    instr_valid = 1'b1;
    instr       = 16'hE7C8;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(posedge clk); #1;
    check("abort_wb_wm_before", {15'h0, write_m}, 16'h0001);
    rst_n = 1'b0;
    #1;
    check("abort_wb_wm_after", {15'h0, write_m}, 16'h0000);
    check("abort_wb_out_m", out_m, 16'h0000);
    model_reset();
    release_reset();
    run_instr(16'h0011);
    run_instr(16'hFC10);   // D=M reads back the untouched location

    // Randomized instruction stream
    for (int t = 0; t < 300; t++) begin
      if ($urandom_range(0, 2) == 0) begin
        if ($urandom_range(0, 3) == 0)
          ins = {1'b0, 15'($urandom)};
        else
          ins = {1'b0, 10'h000, 5'($urandom_range(0, 31))};
      end else begin
        ins = {1'b1, 15'($urandom)};
      end
      // Occasional idle gap before the next instruction.
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      run_instr(ins);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
